// File: rtl/uart_rx_word.sv
// -----------------------------------------------------------------------------
// uart_rx_word
//
// 8N1 UART receiver. It gathers received bytes into a 16-bit display word for
// a seven-segment driver. Each correctly framed byte is shifted into the low
// byte of data_o, and the previous low byte moves up to [15:8].
//
// Parameters
//   CLKFREQ      system clock frequency in Hz
//   BAUD         serial bit rate; one bit lasts BIT_TICKS = CLKFREQ/BAUD cycles
//
// Ports
//   clk          system clock, all logic on the rising edge
//   rst          synchronous, active-high reset
//   rx_i         asynchronous serial line (idle high, LSB first)
//   data_o       display word, newest byte in [7:0]
//   byte_o       last correctly framed byte
//   byte_valid_o one-cycle pulse; byte_o/data_o update on the same edge
//   frame_err_o  one-cycle pulse when the stop bit is sampled low
// -----------------------------------------------------------------------------
module uart_rx_word #(
  parameter int CLKFREQ = 100_000_000,
  parameter int BAUD    = 115_200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_i,
  output logic [15:0] data_o,
  output logic [7:0]  byte_o,
  output logic        byte_valid_o,
  output logic        frame_err_o
);

  localparam int BIT_TICKS  = CLKFREQ / BAUD;
  localparam int HALF_TICKS = BIT_TICKS / 2;
  localparam int CNT_W      = (BIT_TICKS > 2) ? $clog2(BIT_TICKS) : 1;

  // Terminal counts: the middle of the start bit, and one full bit after that.
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  // Two-flop synchronizer. Both flops reset to the idle (high) line level, so
  // reset can never appear to the FSM as a start bit.
  logic rx_meta_q, rx_meta_d;
  logic rx_sync_q, rx_sync_d;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [2:0]       idx_q,   idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [15:0]      data_q,  data_d;
  logic [7:0]       byte_q,  byte_d;
  logic             valid_q, valid_d;
  logic             err_q,   err_d;

  logic rx;
  assign rx = rx_sync_q;

  // NOTE: every _d gets a default before the case statement. This means no
  // path leaves a combinational output unassigned, so no latch can be
  // inferred. The pulses default to 0, which makes them last exactly one cycle.
  always_comb begin
    rx_meta_d = rx_i;
    rx_sync_d = rx_meta_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx) begin
          state_d = S_START;
        end
      end

      // Wait half a bit and re-check the line. A low that has already gone
      // away is treated as a glitch and dropped without any output pulse.
      S_START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d = '0;
          if (!rx) begin
            state_d = S_DATA;
            idx_d   = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // The sample points now fall in the middle of each bit. The line is
      // ignored between sample points.
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // Leave STOP at the middle of the stop bit. That leaves half a bit to
      // catch a start bit that follows immediately.
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx) begin
            byte_d  = shift_q;
            data_d  = {data_q[7:0], shift_q};
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // After a framing error the line may still be low (a break, for
      // example). Look for a new start bit only after the line goes high again.
      S_WAIT_IDLE: begin
        cnt_d = '0;
        if (rx) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Every flop then
  // samples its _d from before the edge, whatever order the lines appear in.
  // NOTE: every flop is reset, including the shift register, so nothing
  // from a frame cut short by reset can reach byte_o or data_o.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 16'h0000;
      byte_q    <= 8'h00;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_sync_q <= rx_sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign data_o       = data_q;
  assign byte_o       = byte_q;
  assign byte_valid_o = valid_q;
  assign frame_err_o  = err_q;

endmodule

// File: tb/tb_uart_rx_word.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_word
//
// Bench for uart_rx_word. The clock and baud values are scaled down so that one
// bit lasts 17 cycles. A frame-level reference model (the line protocol and the
// word shift) predicts every byte_valid_o / frame_err_o event. A negedge
// monitor collects the events the DUT actually produces.
// -----------------------------------------------------------------------------
module tb_uart_rx_word;

  localparam int CLKFREQ = 2_000_000;
  localparam int BAUD    = 115_200;
  localparam int T       = CLKFREQ / BAUD;   // 17 cycles per bit
  localparam int H       = T / 2;
  // Line change to stop-bit pulse: two synchronizer flops, one edge for IDLE
  // to see the low, then H + 9*T cycles to the stop sample point.
  localparam int STOP_LAT = 3 + H + 9 * T;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_i;
  logic [15:0] data_o;
  logic [7:0]  byte_o;
  logic        byte_valid_o;
  logic        frame_err_o;

  uart_rx_word #(.CLKFREQ(CLKFREQ), .BAUD(BAUD)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_i         (rx_i),
    .data_o       (data_o),
    .byte_o       (byte_o),
    .byte_valid_o (byte_valid_o),
    .frame_err_o  (frame_err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int last_start;
  int last_ev_at;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  typedef struct {
    bit          is_err;
    logic [7:0]  b;
    logic [15:0] d;
    int          at;
  } ev_t;

  ev_t ev_q[$];

  always @(negedge clk) begin
    if (byte_valid_o === 1'b1 || frame_err_o === 1'b1) begin
      check("pulse_exclusive", 32'(byte_valid_o & frame_err_o), 32'd0);
      ev_q.push_back(ev_t'{is_err: (frame_err_o === 1'b1), b: byte_o, d: data_o, at: cyc});
    end
  end

  // -------------------------------------------------------- reference model
  logic [15:0] m_data;
  logic [7:0]  m_byte;

  // A good stop bit delivers the byte and shifts it into the display word.
  // A bad stop bit leaves both unchanged.
  task automatic model_frame(input logic [7:0] b, input logic stop);
    if (stop) begin
      m_byte = b;
      m_data = {m_data[7:0], b};
    end
  endtask

  // ------------------------------------------------------------- stimulus
  task automatic hold(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame. Bit i starts at floor(i*per_x100/100) cycles, so the
  // bit period can be fractional. With noise set, each data bit gets a
  // one-cycle inverted pulse well away from its sample point.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int per_x100, input bit noise);
    logic [9:0] bits;
    int dur;
    bits = {stop, b, 1'b0};
    @(posedge clk);
    #1;
    last_start = cyc;
    for (int i = 0; i < 10; i++) begin
      rx_i = bits[i];
      dur  = ((i + 1) * per_x100) / 100 - (i * per_x100) / 100;
      if (noise && i >= 1 && i <= 8) begin
        hold(2);
        rx_i = ~bits[i];
        hold(1);
        rx_i = bits[i];
        hold(dur - 3);
      end else begin
        hold(dur);
      end
    end
  endtask

  task automatic expect_event(input string name, input bit exp_err,
                              input logic [7:0] exp_b, input logic [15:0] exp_d);
    ev_t ev;
    int  waited;
    waited = 0;
    while (ev_q.size() == 0 && waited < 4 * T) begin
      hold(1);
      waited++;
    end
    if (ev_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: no pulse within %0d cycles", name, 4 * T);
    end else begin
      ev = ev_q.pop_front();
      last_ev_at = ev.at;
      check({name, "_kind"}, 32'(ev.is_err), 32'(exp_err));
      check({name, "_byte"}, 32'(ev.b), 32'(exp_b));
      check({name, "_data"}, 32'(ev.d), 32'(exp_d));
    end
  endtask

  task automatic expect_quiet(input string name);
    hold(2);
    check(name, 32'(ev_q.size()), 32'd0);
    ev_q.delete();
  endtask

  // ------------------------------------------------------------ vectors
  typedef struct {
    logic [7:0]  b;
    logic        stop;
    bit          noise;
    bit          exp_err;
    logic [7:0]  exp_byte;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs[7];
  int   b2b_at[10];
  int   gap;
  logic [7:0] rb;
  logic       rstop;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5, 16'h00A5};
    vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C, 16'hA53C};
    vecs[2] = '{8'h55, 1'b0, 1'b0, 1'b1, 8'h3C, 16'hA53C};
    vecs[3] = '{8'h12, 1'b1, 1'b0, 1'b0, 8'h12, 16'h3C12};
    vecs[4] = '{8'h6B, 1'b1, 1'b1, 1'b0, 8'h6B, 16'h126B};
    vecs[5] = '{8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 16'h6B00};
    vecs[6] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF, 16'h00FF};

    // Reset state.
    rst  = 1'b1;
    rx_i = 1'b1;
    hold(3);
    check("reset_data",  32'(data_o), 32'h0);
    check("reset_byte",  32'(byte_o), 32'h0);
    check("reset_valid", 32'(byte_valid_o), 32'h0);
    check("reset_err",   32'(frame_err_o), 32'h0);
    rst    = 1'b0;
    m_data = 16'h0000;
    m_byte = 8'h00;
    hold(T);

    // Table: nominal frames, one bad stop bit followed by a long low, and
    // frames with noise between sample points.
    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].b, vecs[i].stop, T * 100, vecs[i].noise);
      if (!vecs[i].stop) begin
        hold(3 * T);
        rx_i = 1'b1;
      end
      model_frame(vecs[i].b, vecs[i].stop);
      expect_event($sformatf("vec%0d", i), vecs[i].exp_err, vecs[i].exp_byte, vecs[i].exp_data);
      if (i == 0) begin
        check("stop_latency", 32'(last_ev_at - last_start), 32'(STOP_LAT));
      end
      hold(T);
    end
    check("model_after_table", 32'(m_data), 32'h00FF);

    // A low too short to reach the start sample point, and a one-cycle
    // glitch. Neither may produce a pulse.
    rx_i = 1'b0;
    hold(H - 2);
    rx_i = 1'b1;
    hold(2 * T);
    expect_quiet("glitch_long");
    rx_i = 1'b0;
    hold(1);
    rx_i = 1'b1;
    hold(2 * T);
    expect_quiet("glitch_1cyc");
    check("glitch_data_held", 32'(data_o), 32'(m_data));
    send_frame(8'h5A, 1'b1, T * 100, 1'b0);
    model_frame(8'h5A, 1'b1);
    expect_event("after_glitch", 1'b0, m_byte, m_data);
    hold(T);

    // Reset during data bit 4 of 0xFF. The rest of that frame is all ones and
    // must not produce a pulse.
    rx_i = 1'b0;
    hold(T);
    rx_i = 1'b1;
    hold(4 * T + H);
    rst = 1'b1;
    hold(1);
    rst = 1'b0;
    check("midrst_data",  32'(data_o), 32'h0);
    check("midrst_byte",  32'(byte_o), 32'h0);
    check("midrst_valid", 32'(byte_valid_o), 32'h0);
    m_data = 16'h0000;
    m_byte = 8'h00;
    hold(5 * T);
    expect_quiet("midrst_no_pulse");
    send_frame(8'h81, 1'b1, T * 100, 1'b0);
    model_frame(8'h81, 1'b1);
    expect_event("after_rst", 1'b0, 8'h81, 16'h0081);
    hold(T);

    // Reset on the exact edge that samples a good stop bit. Reset must win.
    fork
      send_frame(8'h7E, 1'b1, T * 100, 1'b0);
      begin
        @(posedge clk);
        #1;
        repeat (STOP_LAT - 1) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
    join
    m_data = 16'h0000;
    m_byte = 8'h00;
    expect_quiet("rst_priority_no_pulse");
    check("rst_priority_data", 32'(data_o), 32'h0);
    check("rst_priority_byte", 32'(byte_o), 32'h0);
    hold(T);

    // Ten frames back to back with no idle gap between them.
    for (int i = 0; i < 10; i++) begin
      send_frame(8'(i), 1'b1, T * 100, 1'b0);
    end
    for (int i = 0; i < 10; i++) begin
      model_frame(8'(i), 1'b1);
      expect_event($sformatf("b2b%0d", i), 1'b0, m_byte, m_data);
      b2b_at[i] = last_ev_at;
      if (i > 0) begin
        gap = b2b_at[i] - b2b_at[i-1];
        check($sformatf("b2b_gap%0d", i), 32'(gap >= 10 * T - 1 && gap <= 10 * T + 1), 32'd1);
      end
    end
    check("b2b_final_data", 32'(data_o), 32'h0809);
    hold(T);

    // Bit period 2% short and 2% long.
    send_frame(8'hC3, 1'b1, T * 98, 1'b0);
    model_frame(8'hC3, 1'b1);
    expect_event("baud_fast", 1'b0, 8'hC3, m_data);
    hold(T);
    send_frame(8'hC3, 1'b1, T * 102, 1'b0);
    model_frame(8'hC3, 1'b1);
    expect_event("baud_slow", 1'b0, 8'hC3, m_data);
    hold(T);

    // Random frames: random bytes, rates, noise, gaps and bad stop bits.
    for (int i = 0; i < 16; i++) begin
      rb    = 8'($urandom);
      rstop = ($urandom_range(0, 4) != 0);
      send_frame(rb, rstop, T * (98 + int'($urandom_range(0, 4))), 1'($urandom_range(0, 1)));
      if (!rstop) begin
        hold(int'($urandom_range(T, 3 * T)));
        rx_i = 1'b1;
        hold(T);
      end
      model_frame(rb, rstop);
      expect_event($sformatf("rnd%0d", i), !rstop, m_byte, m_data);
      hold(int'($urandom_range(0, 2 * T)));
    end
    expect_quiet("final_no_extra_pulse");
    check("final_data", 32'(data_o), 32'(m_data));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
